// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store front end for a word-organised data memory.
// Sub-word stores are read-modify-write; misaligned or out-of-range accesses fault without touching memory.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_busy,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_fault,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_resp_rdata;
  logic        r_resp_fault;

  logic        w_load_bad;
  logic        w_store_bad;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_fault;
  logic        w_is_sw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  assign w_load_bad     = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11);
  assign w_store_bad    = i_req_funct3[2] || (i_req_funct3[1:0] == 2'b11);
  assign w_misaligned   = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                          ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
  assign w_out_of_range = i_req_addr >= 32'(DEPTH_WORDS * 4);
  assign w_fault        = (i_req_write ? w_store_bad : w_load_bad) || w_misaligned || w_out_of_range;
  assign w_is_sw        = i_req_write && (i_req_funct3[1:0] == 2'b10);

  // Memory strobes and handshake flags depend on the state register alone, so reset kills them at once.
  assign o_busy       = (r_state != S_IDLE);
  assign o_resp_valid = (r_state == S_DONE);
  assign o_mem_read   = (r_state == S_RD);
  assign o_mem_write  = (r_state == S_WR);
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_fault = r_resp_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (w_fault)      w_next = S_DONE;
          else if (w_is_sw) w_next = S_WR;
          else              w_next = S_RD;
        end
      end
      S_RD:    w_next = r_write ? S_WR : S_DONE;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores, little-endian.
  always_comb begin
    w_byte = i_mem_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'b0, w_byte};
      3'b101:  w_load_data = {16'b0, w_half};
      default: w_load_data = i_mem_rdata;
    endcase
    w_merge_data = i_mem_rdata;
    if (r_funct3[1:0] == 2'b00) w_merge_data[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    else if (r_off[1])          w_merge_data[31:16] = r_wdata;
    else                        w_merge_data[15:0]  = r_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write      <= 1'b0;
      r_funct3     <= 3'b000;
      r_off        <= 2'b00;
      r_wdata      <= 16'h0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_write      <= i_req_write;
            r_funct3     <= i_req_funct3;
            r_off        <= i_req_addr[1:0];
            r_wdata      <= i_req_wdata[15:0];
            r_mem_addr   <= {{(32-IDX_W){1'b0}}, i_req_addr[IDX_W+1:2]};
            r_resp_fault <= w_fault;
            r_resp_rdata <= 32'h0;
            if (!w_fault && w_is_sw) r_mem_wdata <= i_req_wdata;
          end
        end
        S_RD: begin
          if (r_write) r_mem_wdata  <= w_merge_data;
          else         r_resp_rdata <= w_load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random self-checking bench for load_store_unit with a word memory model
// and an independent byte-array reference model.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqWrite = 1'b0;
  logic [2:0]  reqFunct3 = 3'b000;
  logic [31:0] reqAddr = 32'h0;
  logic [31:0] reqWdata = 32'h0;
  logic        busy, respValid, respFault, memRead, memWrite;
  logic [31:0] respRdata, memAddr, memWdata, memRdata;

  logic [31:0] mem [64];
  logic        tbLoad = 1'b0;
  logic [5:0]  tbIdx = 6'd0;
  logic [31:0] tbData = 32'h0;
  logic [7:0]  refMem [256];

  int          nChecks = 0;
  int          nFails = 0;
  int          lat, nr, nw;
  logic [31:0] ra, wa, wd;

  load_store_unit #(.DEPTH_WORDS(64), .IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(reqValid), .i_req_write(reqWrite), .i_req_funct3(reqFunct3),
    .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .o_busy(busy), .o_resp_valid(respValid), .o_resp_rdata(respRdata), .o_resp_fault(respFault),
    .o_mem_read(memRead), .o_mem_write(memWrite), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .i_mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, rising-edge write; tbLoad is the bench's preload port.
  assign memRdata = mem[memAddr[5:0]];
  always @(posedge clk) begin
    if (memWrite)    mem[memAddr[5:0]] <= memWdata;
    else if (tbLoad) mem[tbIdx] <= tbData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("[TB] %s differs", tag);
    end
  endtask

  task automatic preloadWord(input int idx, input logic [31:0] data);
    @(negedge clk);
    tbLoad = 1'b1;
    tbIdx  = idx[5:0];
    tbData = data;
    @(posedge clk);
    #1 tbLoad = 1'b0;
  endtask

  // Issues one request in IDLE and watches the bus until the response pulse (bounded).
  task automatic applyStimulus(input logic write, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output int latency, output int nRead,
                               output int nWrite, output logic [31:0] rdAddr,
                               output logic [31:0] wrAddr, output logic [31:0] wrData);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    reqValid  = 1'b1;
    reqWrite  = write;
    reqFunct3 = f3;
    reqAddr   = addr;
    reqWdata  = wdata;
    @(posedge clk);
    #1 reqValid = 1'b0;
    latency = 0; nRead = 0; nWrite = 0;
    rdAddr = 32'h0; wrAddr = 32'h0; wrData = 32'h0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (memRead) begin
        nRead++;
        rdAddr = memAddr;
      end
      if (memWrite) begin
        nWrite++;
        wrAddr = memAddr;
        wrData = memWdata;
      end
      if (respValid) begin
        latency = i;
        break;
      end
    end
  endtask

  task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] expData);
    applyStimulus(1'b0, f3, addr, 32'h0, lat, nr, nw, ra, wa, wd);
    checkOutput({tag, "_data"}, respRdata, expData);
    checkOutput({tag, "_lat"}, 32'(lat), 32'd2);
    checkOutput({tag, "_fault"}, 32'(respFault), 32'd0);
  endtask

  task automatic doFault(input string tag, input logic write, input logic [2:0] f3,
                         input logic [31:0] addr);
    applyStimulus(write, f3, addr, 32'hFFFF_FFFF, lat, nr, nw, ra, wa, wd);
    checkOutput({tag, "_fault"}, 32'(respFault), 32'd1);
    checkOutput({tag, "_rdata"}, respRdata, 32'h0);
    checkOutput({tag, "_lat"}, 32'(lat), 32'd1);
    checkOutput({tag, "_memops"}, 32'(nr + nw), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed steps, then a random phase against the byte-array reference model.
  initial begin
    int          respCount, writesBefore, totalWrites, secondAt, guard, sawWrite;
    logic [31:0] firstData, expData, wdata;
    logic [2:0]  f3;
    logic        wr;
    int          a, sz;
    logic [2:0]  f3Tab [8];
    f3Tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};

    #2 rst_n = 1'b0;
    #10;
    checkOutput("reset_flags", {27'b0, busy, respValid, respFault, memRead, memWrite}, 32'h0);
    checkOutput("reset_mem_addr", memAddr, 32'h0);
    checkOutput("reset_mem_wdata", memWdata, 32'h0);
    checkOutput("reset_resp_rdata", respRdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    preloadWord(5, 32'h80F0_7F01);
    preloadWord(17, 32'h1122_3344);
    preloadWord(20, 32'h0);
    preloadWord(63, 32'h9A00_0000);

    $display("[TB] directed loads");
    doLoad("lb_15", 3'b000, 32'h15, 32'h0000_007F);
    doLoad("lb_16", 3'b000, 32'h16, 32'hFFFF_FFF0);
    doLoad("lbu_17", 3'b100, 32'h17, 32'h0000_0080);
    doLoad("lh_16", 3'b001, 32'h16, 32'hFFFF_80F0);
    doLoad("lhu_16", 3'b101, 32'h16, 32'h0000_80F0);
    doLoad("lw_14", 3'b010, 32'h14, 32'h80F0_7F01);
    checkOutput("lw_14_rdaddr", ra, 32'd5);
    doLoad("lb_ff", 3'b000, 32'hFF, 32'hFFFF_FF9A);

    $display("[TB] directed stores");
    applyStimulus(1'b1, 3'b000, 32'h45, 32'hFFFF_FFAB, lat, nr, nw, ra, wa, wd);
    checkOutput("sb_45_lat", 32'(lat), 32'd3);
    checkOutput("sb_45_ops", 32'({nr[3:0], nw[3:0]}), 32'h11);
    checkOutput("sb_45_wdata", wd, 32'h1122_AB44);
    checkOutput("sb_45_rdaddr", ra, 32'd17);
    checkOutput("sb_45_wraddr", wa, 32'd17);
    checkOutput("sb_45_rdata", respRdata, 32'h0);
    checkOutput("sb_45_mem", mem[17], 32'h1122_AB44);
    applyStimulus(1'b1, 3'b001, 32'h46, 32'h1234_BEEF, lat, nr, nw, ra, wa, wd);
    checkOutput("sh_46_lat", 32'(lat), 32'd3);
    checkOutput("sh_46_wdata", wd, 32'hBEEF_AB44);
    checkOutput("sh_46_mem", mem[17], 32'hBEEF_AB44);
    applyStimulus(1'b1, 3'b010, 32'h50, 32'hDEAD_BEEF, lat, nr, nw, ra, wa, wd);
    checkOutput("sw_50_lat", 32'(lat), 32'd2);
    checkOutput("sw_50_ops", 32'({nr[3:0], nw[3:0]}), 32'h01);
    checkOutput("sw_50_wdata", wd, 32'hDEAD_BEEF);
    checkOutput("sw_50_wraddr", wa, 32'd20);

    $display("[TB] faults");
    doLoad("lw_pre_fault", 3'b010, 32'h14, 32'h80F0_7F01);
    doFault("lw_42", 1'b0, 3'b010, 32'h42);
    doFault("sh_41", 1'b1, 3'b001, 32'h41);
    doFault("ld_f3_011", 1'b0, 3'b011, 32'h14);
    doFault("st_f3_100", 1'b1, 3'b100, 32'h14);
    doFault("lw_100", 1'b0, 3'b010, 32'h100);
    doFault("lb_100", 1'b0, 3'b000, 32'h100);

    $display("[TB] store requested while busy");
    @(negedge clk);
    guard = 0;
    while (busy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    reqValid = 1'b1; reqWrite = 1'b0; reqFunct3 = 3'b010; reqAddr = 32'h14; reqWdata = 32'h0;
    @(posedge clk);
    #1;
    reqWrite = 1'b1; reqAddr = 32'h50; reqWdata = 32'hCAFE_F00D;
    respCount = 0; writesBefore = 0; totalWrites = 0; secondAt = 0; firstData = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (memWrite) begin
        totalWrites++;
        if (respCount == 0) writesBefore++;
      end
      if (respValid) begin
        respCount++;
        if (respCount == 1) firstData = respRdata;
        else begin
          secondAt = i;
          reqValid = 1'b0;
          break;
        end
      end
    end
    checkOutput("busy_sw_first_data", firstData, 32'h80F0_7F01);
    checkOutput("busy_sw_early_writes", 32'(writesBefore), 32'd0);
    checkOutput("busy_sw_resp_count", 32'(respCount), 32'd2);
    checkOutput("busy_sw_second_at", 32'(secondAt), 32'd5);
    repeat (3) @(negedge clk);
    checkOutput("busy_sw_total_writes", 32'(totalWrites), 32'd1);
    checkOutput("busy_sw_idle_after", 32'(busy), 32'd0);
    checkOutput("busy_sw_mem", mem[20], 32'hCAFE_F00D);

    $display("[TB] reset during write");
    preloadWord(10, 32'h5566_7788);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'b000; reqAddr = 32'h28; reqWdata = 32'h11;
    @(posedge clk);
    #1 reqValid = 1'b0;
    sawWrite = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (memWrite) begin
        sawWrite = 1;
        break;
      end
    end
    checkOutput("rst_wr_reached", 32'(sawWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wr_flags", {27'b0, busy, respValid, respFault, memRead, memWrite}, 32'h0);
    checkOutput("rst_wr_mem_addr", memAddr, 32'h0);
    checkOutput("rst_wr_mem_wdata", memWdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_wr_busy_after", 32'(busy), 32'd0);
    checkOutput("rst_wr_no_write", mem[10], 32'h5566_7788);

    $display("[TB] random accesses");
    for (int w = 0; w < 64; w++) begin
      wdata = $urandom;
      preloadWord(w, wdata);
      for (int b = 0; b < 4; b++) refMem[w*4+b] = wdata[b*8 +: 8];
    end
    for (int n = 0; n < 2000; n++) begin
      a     = $urandom_range(0, 7);
      f3    = f3Tab[a];
      wr    = (a >= 5);
      sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      a     = $urandom_range(0, 255);
      a     = a - (a % sz);
      wdata = $urandom;
      applyStimulus(wr, f3, 32'(a), wdata, lat, nr, nw, ra, wa, wd);
      checkOutput("rnd_fault", {31'b0, respFault}, 32'h0);
      if (wr) begin
        for (int b = 0; b < sz; b++) refMem[a+b] = wdata[b*8 +: 8];
      end else begin
        case (f3)
          3'b000:  expData = {{24{refMem[a][7]}}, refMem[a]};
          3'b001:  expData = {{16{refMem[a+1][7]}}, refMem[a+1], refMem[a]};
          3'b100:  expData = {24'b0, refMem[a]};
          3'b101:  expData = {16'b0, refMem[a+1], refMem[a]};
          default: expData = {refMem[a+3], refMem[a+2], refMem[a+1], refMem[a]};
        endcase
        checkOutput("rnd_load", respRdata, expData);
      end
    end
    @(negedge clk);
    for (int w = 0; w < 64; w++)
      checkOutput($sformatf("final_mem_%0d", w), mem[w],
                  {refMem[w*4+3], refMem[w*4+2], refMem[w*4+1], refMem[w*4]});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the core's execute stage and the word-organised data memory; converts byte-addressed RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Sub-word stores are done as read-modify-write, since the data memory only writes whole 32-bit words. Misaligned and out-of-range accesses are rejected with a fault and never reach memory. The core stalls on `busy` and consumes a one-cycle response pulse.

## Interface
- `DEPTH_WORDS`, 64: data memory depth in 32-bit words; must be a power of two.
- `IDX_W`, 6: word-index width, equal to log2(`DEPTH_WORDS`).
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: access request; sampled only in IDLE.
- `req_write` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V funct3 size/sign code.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data; the low byte/half is used for SB/SH.
- `busy` output 1: high whenever state is not IDLE.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load data; 0 for stores and faults.
- `resp_fault` output 1: qualifies `resp_valid`; the access was rejected.
- `mem_read` output 1: memory read enable; memory read is combinational.
- `mem_write` output 1: memory write enable; memory writes on the rising edge.
- `mem_addr` output 32: word index, zero-extended from `IDX_W` bits.
- `mem_wdata` output 32: full word to write.
- `mem_rdata` input 32: memory read data.

## Operation
- FSM states:
  - IDLE, RD, WR, DONE.
  - `mem_read`, `mem_write` and `busy` are decoded from the state register only.
  - `mem_addr` and `mem_wdata` come from registers.
- IDLE with `req_valid`: latch the request, set `mem_addr` = `req_addr[IDX_W+1:2]`, then branch:
  - Fault → DONE. A fault is any of:
    - illegal funct3 (loads: 011, 110, 111; stores: anything above 010);
    - `req_addr[31:IDX_W+2]` ≠ 0;
    - halfword with `addr[0]`=1;
    - word with `addr[1:0]` ≠ 0.
  - Load → RD.
  - SW → WR with `mem_wdata` = `req_wdata`.
  - SB/SH → RD.
- RD: `mem_read`=1.
  - At the edge, capture `mem_rdata`.
  - Load: extract the lane selected by `addr[1:0]` (byte) or `addr[1]` (half). Sign-extend for LB/LH, zero-extend for LBU/LHU, pass whole word for LW. Result goes to `resp_rdata`; next state DONE.
  - SB/SH: merge the new byte/half into the captured word at the same lane, leaving the other lanes unchanged. Result goes to `mem_wdata`; next state WR.
- WR: `mem_write`=1 for exactly one cycle; next state DONE.
- DONE: `resp_valid`=1 and `busy`=1; next state IDLE. `resp_fault`/`resp_rdata` hold until the next accept.
- `req_valid` outside IDLE is ignored; the core must hold the request until `busy` falls.
- Lane order is little-endian: byte 0 = bits 7:0.

## Timing
- Latency from accept edge E0 to the cycle in which `resp_valid` is high:
  - fault: 1 cycle;
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles.
- Back-to-back throughput: a new request can be accepted on the edge that leaves DONE (the next IDLE cycle). Sustained rate is one load every 3 cycles.
- Reset values: state IDLE; all outputs 0, including `mem_addr`, `mem_wdata`, `resp_rdata` and `resp_fault`.
- Reset asserted mid-operation:
  - FSM goes to IDLE immediately and `mem_write` drops asynchronously.
  - An RMW interrupted after RD performs no write.
- RD and WR for the same RMW use an identical `mem_addr`. No other agent writes memory in between (single core).

## Test plan
- Reset: assert `rst_n`=0 while in WR → `mem_write`=0 within the same cycle, all outputs 0; after release, `busy`=0.
- Loads with `mem[5]`=0x80F0_7F01 at addr 0x14–0x17:
  - LB 0x15 → 0x0000_007F;
  - LB 0x16 → 0xFFFF_FFF0;
  - LBU 0x17 → 0x0000_0080;
  - LH 0x16 → 0xFFFF_80F0;
  - LW 0x14 → 0x80F0_7F01.
  - Each shows `resp_valid` exactly 2 cycles after accept.
- SB 0xAB to 0x45 with `mem[17]`=0x1122_3344 → one RD then one WR with `mem_wdata`=0x1122_AB44, `mem_addr`=17, `resp_valid` 3 cycles after accept. SH 0xBEEF to 0x46 afterwards → 0xBEEF_AB44.
- Faults:
  - LW 0x42, SH 0x41, funct3=011, and addr 0x100 (out of range for 64 words) each → `resp_fault`=1, `resp_rdata`=0, `resp_valid` after 1 cycle.
  - Neither `mem_read` nor `mem_write` is ever asserted.
- Request handling:
  - Hold `req_valid` high continuously with changing data → each request is accepted only in IDLE and none is lost or duplicated.
  - An SW while busy takes effect only after `busy` falls.
- Random: 2000 mixed accesses against a byte-array reference model → all load data and final memory contents match.
